// File: rtl/adc_capture_sequencer_if.sv
// adc_capture_sequencer_if: ADC strobe, capture FIFO ports and output stream of one capture channel
interface adc_capture_sequencer_if #(
   parameter int DATA_W = 12
);
   logic              adc_valid;
   logic [DATA_W-1:0] adc_data;
   logic              fifo_srst;
   logic              fifo_wr_en;
   logic [DATA_W-1:0] fifo_din;
   logic              fifo_full;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_empty;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready;

   modport master (
      input  adc_valid, adc_data, fifo_full, fifo_dout, fifo_empty, m_ready,
      output fifo_srst, fifo_wr_en, fifo_din, fifo_rd_en, m_valid, m_data
   );

   modport slave (
      output adc_valid, adc_data, fifo_full, fifo_dout, fifo_empty, m_ready,
      input  fifo_srst, fifo_wr_en, fifo_din, fifo_rd_en, m_valid, m_data
   );
endinterface

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: clear FIFO, optional level trigger, decimated capture until full, then drain to a stream
module adc_capture_sequencer #(
   parameter int DATA_W  = 12,
   parameter int DECIM_W = 16,
   parameter int CLR_CYC = 4,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [DECIM_W-1:0]     decim,
   input  logic                   trig_en,
   input  logic [DATA_W-1:0]      trig_level,
   adc_capture_sequencer_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic                   aborted,
   output logic [CNT_W-1:0]       sample_cnt
);
   typedef enum logic [2:0] {IDLE, CLEAR, ARM, CAPTURE, DRAIN, DONE} state_t;
   localparam int CLR_W = $clog2(CLR_CYC + 1);

   state_t             state, state_nx;
   logic [CLR_W-1:0]   clr_cnt;
   logic [DECIM_W-1:0] dec_cnt;
   logic [DATA_W-1:0]  prev;
   logic               have_prev;
   logic               rd_q;
   logic               trig;
   logic               wr_nx;

   // a trigger needs an earlier sample from this ARM visit below the level and the current one at or above it
   assign trig  = state == ARM && trig_en && bus.adc_valid && have_prev &&
                  prev < trig_level && bus.adc_data >= trig_level;
   // writes come from the triggering sample or a count-0 strobe while the FIFO still has room
   assign wr_nx = !abort && (trig || (state == CAPTURE && bus.adc_valid &&
                  dec_cnt == '0 && !bus.fifo_full));

   // next state plus the state-decoded FIFO clear, stream and status outputs
   always_comb begin
      state_nx       = state;
      bus.fifo_srst  = state == CLEAR;
      bus.m_valid    = state == DRAIN && !bus.fifo_empty;
      bus.m_data     = bus.fifo_dout;
      bus.fifo_rd_en = state == DRAIN && !bus.fifo_empty && bus.m_ready;
      busy           = state != IDLE;
      done           = state == DONE;
      case (state)
         IDLE:    if (start) state_nx = CLEAR;
         CLEAR:   if (clr_cnt == CLR_W'(CLR_CYC - 1)) state_nx = ARM;
         ARM:     if (!trig_en || trig) state_nx = CAPTURE;
         CAPTURE: if (bus.fifo_full) state_nx = DRAIN;
         DRAIN:   if (bus.fifo_empty && !rd_q) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end

   // state, clear/decimation counters, trigger history, registered write port and sample count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         clr_cnt        <= '0;
         dec_cnt        <= '0;
         prev           <= '0;
         have_prev      <= 1'b0;
         rd_q           <= 1'b0;
         aborted        <= 1'b0;
         sample_cnt     <= '0;
         bus.fifo_wr_en <= 1'b0;
         bus.fifo_din   <= '0;
      end else begin
         state          <= state_nx;
         rd_q           <= bus.fifo_rd_en;
         aborted        <= abort && state != IDLE;
         bus.fifo_wr_en <= wr_nx;
         if (wr_nx) bus.fifo_din <= bus.adc_data;
         clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
         if (state != ARM) have_prev <= 1'b0;
         else if (bus.adc_valid) begin
            have_prev <= 1'b1;
            prev      <= bus.adc_data;
         end
         if (state != CAPTURE) dec_cnt <= trig && decim != '0 ? DECIM_W'(1) : '0;
         else if (bus.adc_valid) dec_cnt <= dec_cnt == decim ? '0 : dec_cnt + 1'b1;
         if (state == IDLE && start && !abort) sample_cnt <= '0;
         else if (bus.fifo_wr_en && sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: table, directed and randomized checks of the capture sequencer with a FIFO model
module tb_adc_capture_sequencer;
   localparam int DATA_W  = 12;
   localparam int DECIM_W = 16;
   localparam int CLR_CYC = 4;
   localparam int CNT_W   = 16;
   localparam int DEPTH   = 16;
   localparam int N       = 300;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              wr;
   } vec_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic               trig_en = 1'b0;
   logic [DECIM_W-1:0] decim = '0;
   logic [DATA_W-1:0]  trig_level = '0;
   logic               busy, done, aborted;
   logic [CNT_W-1:0]   sample_cnt;
   int                 total = 0;
   int                 bad = 0;

   adc_capture_sequencer_if #(.DATA_W(DATA_W)) bus ();

   adc_capture_sequencer #(
      .DATA_W(DATA_W), .DECIM_W(DECIM_W), .CLR_CYC(CLR_CYC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .decim(decim),
      .trig_en(trig_en), .trig_level(trig_level), .bus(bus), .busy(busy),
      .done(done), .aborted(aborted), .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;

   // 16-deep first-word-fall-through FIFO with synchronous clear; writes when full are dropped
   logic [DATA_W-1:0] f_mem [DEPTH];
   logic [3:0]        f_wp = '0;
   logic [3:0]        f_rp = '0;
   logic [4:0]        f_cnt = '0;
   logic              f_wr, f_rd;
   assign f_wr           = bus.fifo_wr_en && !bus.fifo_full;
   assign f_rd           = bus.fifo_rd_en && !bus.fifo_empty;
   assign bus.fifo_full  = f_cnt == 5'(DEPTH);
   assign bus.fifo_empty = f_cnt == 5'd0;
   assign bus.fifo_dout  = f_mem[f_rp];
   always @(posedge clk) begin
      if (bus.fifo_srst) begin
         f_wp  <= '0;
         f_rp  <= '0;
         f_cnt <= '0;
      end else begin
         if (f_wr) begin
            f_mem[f_wp] <= bus.fifo_din;
            f_wp        <= f_wp + 4'd1;
         end
         if (f_rd) f_rp <= f_rp + 4'd1;
         f_cnt <= f_cnt + 5'(f_wr) - 5'(f_rd);
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // monitor: write/pop logs, write-after-full, stream stability, done and clear counts
   logic [DATA_W-1:0] wr_log[$];
   logic [DATA_W-1:0] pop_log[$];
   int                done_cnt = 0;
   int                srst_cnt = 0;
   logic              prev_full = 1'b0;
   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   always @(negedge clk) begin
      if (bus.fifo_wr_en) begin
         wr_log.push_back(bus.fifo_din);
         chk("no_wr_after_full", prev_full, 0);
      end
      prev_full <= bus.fifo_full;
      if (bus.m_valid && bus.m_ready) pop_log.push_back(bus.m_data);
      if (!rst_n) prev_stall <= 1'b0;
      else begin
         if (prev_stall) begin
            chk("stall_valid", bus.m_valid, 1);
            chk("stall_data", bus.m_data, prev_data);
         end
         prev_stall <= bus.m_valid && !bus.m_ready;
         prev_data  <= bus.m_data;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         chk("done_after_drain", pop_log.size(), DEPTH);
      end
      if (bus.fifo_srst) srst_cnt <= srst_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      bus.adc_valid = 1'b0;
      bus.adc_data  = '0;
      bus.m_ready   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_idle(input string t);
      chk({t, "_busy"}, busy, 0);
      chk({t, "_done"}, done, 0);
      chk({t, "_aborted"}, aborted, 0);
      chk({t, "_srst"}, bus.fifo_srst, 0);
      chk({t, "_wr_en"}, bus.fifo_wr_en, 0);
      chk({t, "_din"}, bus.fifo_din, 0);
      chk({t, "_sample_cnt"}, sample_cnt, 0);
      chk({t, "_m_valid"}, bus.m_valid, 0);
      chk({t, "_rd_en"}, bus.fifo_rd_en, 0);
   endtask

   // full capture run; expected words come from the strobe list, trigger rule and decimation stride
   task automatic run_capture(input int dc, input bit te, input int lvl, input int gap,
                              input int rmode, input bit ramp);
      logic [DATA_W-1:0] samp [N];
      logic [DATA_W-1:0] exp_q[$];
      logic [DATA_W-1:0] wr_exp[$];
      int i0 = 0;
      int j = 0;
      int gapc = 0;
      int cyc = 0;
      int exp_cnt = DEPTH;
      for (int k = 0; k < N; k++) samp[k] = ramp ? DATA_W'(k) : DATA_W'($urandom);
      if (te) begin
         samp[5] = DATA_W'(lvl - 1);
         samp[6] = DATA_W'(lvl);
         i0 = -1;
         for (int k = 1; k < N && i0 < 0; k++)
            if (samp[k-1] < DATA_W'(lvl) && samp[k] >= DATA_W'(lvl)) i0 = k;
      end
      for (int k = i0; k < N && exp_q.size() < DEPTH; k += dc + 1) exp_q.push_back(samp[k]);
      wr_exp = exp_q;
      if (gap == 1 && dc == 0) begin
         wr_exp.push_back(samp[i0 + DEPTH]);
         exp_cnt++;
      end
      do_reset();
      decim      = DECIM_W'(dc);
      trig_en    = te;
      trig_level = DATA_W'(lvl);
      wr_log.delete();
      pop_log.delete();
      done_cnt = 0;
      srst_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      while (done_cnt == 0 && cyc < 4000) begin
         bus.adc_valid = 1'b0;
         if (gapc == 0 && j < N) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = samp[j];
            j++;
            gapc = gap - 1;
         end else if (gapc > 0) gapc--;
         start       = cyc == 25;
         bus.m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      bus.adc_valid = 1'b0;
      start         = 1'b0;
      bus.m_ready   = 1'b0;
      repeat (3) tick();
      chk("done_once", done_cnt, 1);
      chk("busy_after_done", busy, 0);
      chk("srst_cycles", srst_cnt, CLR_CYC);
      chk("sample_cnt", sample_cnt, exp_cnt);
      chk("wr_count", wr_log.size(), wr_exp.size());
      for (int k = 0; k < wr_exp.size() && k < wr_log.size(); k++)
         chk($sformatf("wr_word[%0d]", k), wr_log[k], wr_exp[k]);
      chk("pop_count", pop_log.size(), DEPTH);
      for (int k = 0; k < DEPTH && k < pop_log.size(); k++)
         chk($sformatf("pop_word[%0d]", k), pop_log[k], exp_q[k]);
   endtask

   initial begin
      vec_t tbl [7];
      tbl[0] = '{150, 0};
      tbl[1] = '{90, 0};
      tbl[2] = '{95, 0};
      tbl[3] = '{120, 1};
      tbl[4] = '{80, 1};
      tbl[5] = '{99, 1};
      tbl[6] = '{100, 1};

      do_reset();
      @(negedge clk);
      chk_idle("reset");

      run_capture(0, 0, 0, 2, 0, 1);
      run_capture(3, 0, 0, 2, 0, 1);
      run_capture(0, 0, 0, 2, 1, 1);
      run_capture(0, 0, 0, 1, 0, 1);
      repeat (6)
         run_capture($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(1, 4095),
                     $urandom_range(2, 4), 2, 0);

      // trigger table, then abort mid-capture
      do_reset();
      decim      = '0;
      trig_en    = 1'b1;
      trig_level = 12'd100;
      wr_log.delete();
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      for (int k = 0; k < 7; k++) begin
         bus.adc_valid = 1'b1;
         bus.adc_data  = tbl[k].data;
         tick();
         bus.adc_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("tbl_wr[%0d]", k), bus.fifo_wr_en, tbl[k].wr);
         if (tbl[k].wr) chk($sformatf("tbl_din[%0d]", k), bus.fifo_din, tbl[k].data);
         tick();
      end
      bus.adc_valid = 1'b1;
      bus.adc_data  = 12'd555;
      abort         = 1'b1;
      tick();
      abort         = 1'b0;
      bus.adc_valid = 1'b0;
      @(negedge clk);
      chk("abort_pulse", aborted, 1);
      chk("abort_busy", busy, 0);
      chk("abort_wr", bus.fifo_wr_en, 0);
      chk("abort_cnt_hold", sample_cnt, 4);
      tick();
      @(negedge clk);
      chk("abort_pulse_end", aborted, 0);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_wr_total", wr_log.size(), 4);

      // restart after abort: exact clear window
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("srst_cyc[%0d]", k), bus.fifo_srst, k < CLR_CYC);
         if (k == 0) chk("restart_cnt_clear", sample_cnt, 0);
         tick();
      end
      abort = 1'b1;
      tick();
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("start_abort_busy", busy, 0);
      chk("start_abort_srst", bus.fifo_srst, 0);
      chk("start_abort_no_pulse", aborted, 0);

      // reset while stalled in DRAIN; a start while busy is ignored
      do_reset();
      decim   = '0;
      trig_en = 1'b0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      repeat (24) begin
         bus.adc_valid = 1'b1;
         bus.adc_data  = DATA_W'($urandom);
         tick();
         bus.adc_valid = 1'b0;
         tick();
      end
      @(negedge clk);
      chk("drain_busy", busy, 1);
      chk("drain_valid", bus.m_valid, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("busy_start_ignored", bus.fifo_srst, 0);
      rst_n       = 1'b0;
      bus.m_ready = 1'b1;
      tick();
      @(negedge clk);
      chk_idle("rst_mid_drain");
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
